// File: rtl/ln_normalize_stage.sv
// LayerNorm stage-3 normalizer.
// Fetches a pixel's mean / reciprocal deviation from the stats SRAM, then
// streams that pixel's channel beats through a 3-stage per-lane pipeline:
//   y = sat(round(((x - mean) * recip) >>> shift))
// Rounding is half-up toward +inf. The result saturates to the signed
// element range.

// ---------------------------------------------------------------------------
// One lane of the normalizer datapath.
// S1 subtracts the mean. S2 multiplies by the reciprocal.
// S3 rounds, shifts and saturates.
// ---------------------------------------------------------------------------
module ln_norm_lane #(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            s1_en,
  input  logic            s2_en,
  input  logic            s3_en,
  input  logic [DW-1:0]   x,
  input  logic [DW-1:0]   mean,
  input  logic [2*DW-1:0] recip,
  input  logic [4:0]      shift,
  output logic [DW-1:0]   y
);

  // Product width: (DW+1) signed times (2*DW+1) signed.
  localparam int PW = 3*DW + 2;
  // Headroom for a rounding constant of up to 1<<30.
  localparam int SW = PW + 32;

  logic signed [DW:0]   diff_r;
  logic [2*DW-1:0]      recip_s1;
  logic signed [PW-1:0] prod_d;
  logic signed [PW-1:0] prod_r;
  logic signed [SW-1:0] rnd;
  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] res;
  logic [DW-1:0]        sat;
  logic                 fits;

  // S1: difference against the mean.
  // The reciprocal rides along with the beat, so later stat updates
  // cannot disturb beats that are already in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_r   <= '0;
      recip_s1 <= '0;
    end else if (s1_en) begin
      diff_r   <= {x[DW-1], x} - {mean[DW-1], mean};
      recip_s1 <= recip;
    end
  end

  // S2 operand: the reciprocal is unsigned, so it gets a zero sign bit.
  always_comb prod_d = diff_r * $signed({1'b0, recip_s1});

  // S2: register the product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      prod_r <= '0;
    else if (s2_en)  prod_r <= prod_d;
  end

  // S3 datapath: add half an LSB of the shifted result, then shift
  // arithmetically. This gives round-half-up (toward +inf). Saturate if
  // the bits above the sign do not all match it.
  always_comb begin
    rnd = '0;
    if (shift != 5'd0) rnd = SW'(1) << (shift - 5'd1);
    sum  = {{(SW-PW){prod_r[PW-1]}}, prod_r} + rnd;
    res  = sum >>> shift;
    fits = (&res[SW-1:DW-1]) || !(|res[SW-1:DW-1]);
    if (fits)              sat = res[DW-1:0];
    else if (res[SW-1])    sat = {1'b1, {(DW-1){1'b0}}};
    else                   sat = {1'b0, {(DW-1){1'b1}}};
  end

  // S3: register the normalized element.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      y <= '0;
    else if (s3_en)  y <= sat;
  end

endmodule

// ---------------------------------------------------------------------------
// Top: layer sequencer (IDLE/FETCH/WAIT/RUN/DRAIN) plus the lane array.
// ---------------------------------------------------------------------------
module ln_normalize_stage #(
  parameter int MAX_DAT_DW    = 8,
  parameter int LANES         = 4,
  parameter int Log2_LN_pixel = 6,
  parameter int CH_W          = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [Log2_LN_pixel:0]      cfg_pix_num,
  input  logic [CH_W-1:0]             cfg_ch_num,
  input  logic [4:0]                  cfg_shift,
  output logic                        busy,
  output logic                        done,
  output logic                        stat_rd_en,
  output logic [Log2_LN_pixel-1:0]    stat_rd_addr,
  input  logic [MAX_DAT_DW-1:0]       stat_mean,
  input  logic [2*MAX_DAT_DW-1:0]     stat_recip,
  input  logic                        stat_vld,
  input  logic                        dat_in_vld,
  output logic                        dat_in_rdy,
  input  logic [MAX_DAT_DW*LANES-1:0] dat_in,
  output logic                        dat_out_vld,
  output logic [MAX_DAT_DW*LANES-1:0] dat_out,
  output logic                        dat_out_last
);

  localparam int DW   = MAX_DAT_DW;
  localparam int AW   = Log2_LN_pixel;
  localparam int AW1  = AW + 1;
  localparam int NSTG = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_RUN,
    ST_DRAIN
  } state_t;

  state_t                     state;
  state_t                     state_nxt;
  logic [AW:0]                pix_num_r;
  logic [CH_W-1:0]            ch_num_r;
  logic [4:0]                 shift_r;
  logic [AW-1:0]              pix_cnt;
  logic [CH_W-1:0]            ch_cnt;
  logic [DW-1:0]              mean_r;
  logic [2*DW-1:0]            recip_r;
  logic [1:0]                 drain_cnt;
  logic                       done_r;
  logic [NSTG-1:0]            vld_pipe;
  logic [NSTG-1:0]            last_pipe;
  logic                       xfer;
  logic                       ch_end;
  logic                       pix_more;
  logic [LANES-1:0][DW-1:0]   x_lanes;
  logic [LANES-1:0][DW-1:0]   y_lanes;

  assign x_lanes = dat_in;
  assign dat_out = y_lanes;

  assign xfer     = (state == ST_RUN) && dat_in_vld;
  assign ch_end   = (ch_cnt == (ch_num_r - CH_W'(1)));
  assign pix_more = (({1'b0, pix_cnt} + AW1'(1)) < pix_num_r);

  assign busy         = (state != ST_IDLE);
  assign stat_rd_en   = (state == ST_FETCH);
  assign stat_rd_addr = stat_rd_en ? pix_cnt : '0;
  assign dat_in_rdy   = (state == ST_RUN);
  assign done         = done_r;
  assign dat_out_vld  = vld_pipe[NSTG-1];
  assign dat_out_last = last_pipe[NSTG-1];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  // There is no read-ahead, so each pixel pays FETCH and WAIT as bubbles.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (start) state_nxt = (cfg_pix_num == '0) ? ST_DRAIN : ST_FETCH;
      ST_FETCH: state_nxt = ST_WAIT;
      ST_WAIT:  if (stat_vld) state_nxt = ST_RUN;
      ST_RUN:   if (xfer && ch_end) state_nxt = pix_more ? ST_FETCH : ST_DRAIN;
      ST_DRAIN: if (drain_cnt == 2'd2) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Config latch, pixel/channel counters, stats capture and drain timer.
  // pix_cnt stops at the last pixel so the read address never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_num_r <= '0;
      ch_num_r  <= '0;
      shift_r   <= '0;
      pix_cnt   <= '0;
      ch_cnt    <= '0;
      mean_r    <= '0;
      recip_r   <= '0;
      drain_cnt <= '0;
    end else begin
      unique case (state)
        ST_IDLE: if (start) begin
          pix_num_r <= cfg_pix_num;
          ch_num_r  <= cfg_ch_num;
          shift_r   <= cfg_shift;
          pix_cnt   <= '0;
          ch_cnt    <= '0;
          drain_cnt <= '0;
        end
        ST_WAIT: if (stat_vld) begin
          mean_r  <= stat_mean;
          recip_r <= stat_recip;
        end
        ST_RUN: if (xfer) begin
          if (ch_end) begin
            ch_cnt <= '0;
            if (pix_more) pix_cnt <= pix_cnt + AW'(1);
          end else begin
            ch_cnt <= ch_cnt + CH_W'(1);
          end
        end
        ST_DRAIN: drain_cnt <= (drain_cnt == 2'd2) ? 2'd0 : drain_cnt + 2'd1;
        default: ;
      endcase
    end
  end

  // Done pulses in the cycle after the drain completes, when busy has
  // already fallen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done_r <= 1'b0;
    else        done_r <= (state == ST_DRAIN) && (drain_cnt == 2'd2);
  end

  // Valid and last shift registers, one bit per pipeline stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[NSTG-2:0], xfer};
      last_pipe <= {last_pipe[NSTG-2:0], xfer && ch_end && !pix_more};
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    ln_norm_lane #(.DW(DW)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .s1_en (xfer),
      .s2_en (vld_pipe[0]),
      .s3_en (vld_pipe[1]),
      .x     (x_lanes[l]),
      .mean  (mean_r),
      .recip (recip_r),
      .shift (shift_r),
      .y     (y_lanes[l])
    );
  end

endmodule

// File: tb/tb_ln_normalize_stage.sv
// Scoreboard bench for ln_normalize_stage.
// The stimulus pushes expected beats from an arithmetic reference model.
// The monitor pops and compares them whenever dat_out_vld is high.
module tb_ln_normalize_stage;

  localparam int DW = 8;
  localparam int L  = 4;
  localparam int AW = 6;
  localparam int CW = 16;
  localparam int BW = DW * L;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [AW:0]     cfg_pix_num;
  logic [CW-1:0]   cfg_ch_num;
  logic [4:0]      cfg_shift;
  logic            busy;
  logic            done;
  logic            stat_rd_en;
  logic [AW-1:0]   stat_rd_addr;
  logic [DW-1:0]   stat_mean;
  logic [2*DW-1:0] stat_recip;
  logic            stat_vld;
  logic            dat_in_vld;
  logic            dat_in_rdy;
  logic [BW-1:0]   dat_in;
  logic            dat_out_vld;
  logic [BW-1:0]   dat_out;
  logic            dat_out_last;

  ln_normalize_stage #(.MAX_DAT_DW(DW), .LANES(L), .Log2_LN_pixel(AW), .CH_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_pix_num(cfg_pix_num),
    .cfg_ch_num(cfg_ch_num), .cfg_shift(cfg_shift), .busy(busy), .done(done),
    .stat_rd_en(stat_rd_en), .stat_rd_addr(stat_rd_addr), .stat_mean(stat_mean),
    .stat_recip(stat_recip), .stat_vld(stat_vld), .dat_in_vld(dat_in_vld),
    .dat_in_rdy(dat_in_rdy), .dat_in(dat_in), .dat_out_vld(dat_out_vld),
    .dat_out(dat_out), .dat_out_last(dat_out_last)
  );

  typedef struct {
    logic [BW-1:0] d;
    logic          last;
    int            cyc;
  } exp_t;

  exp_t                  exp_q[$];
  logic [BW-1:0]         dir_q[$];
  logic signed [DW-1:0]  mean_mem  [64];
  logic [2*DW-1:0]       recip_mem [64];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int stat_dly = 1;
  int fetch_idx = 0;
  int exp_pix = 0;
  bit awaiting_done = 0;
  bit abort = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain integer arithmetic. >>> on a signed longint is
  // floor division by 2^sh.
  function automatic logic [DW-1:0] ref_norm(input int x, input int m, input int r, input int sh);
    longint p;
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (DW-1)) - 1;
    lo = -(longint'(1) <<< (DW-1));
    p = longint'(x - m) * longint'(r);
    if (sh > 0) p = p + (longint'(1) <<< (sh-1));
    p = p >>> sh;
    if (p > hi) p = hi;
    if (p < lo) p = lo;
    return p[DW-1:0];
  endfunction

  // Stats SRAM model. It answers each read stat_dly cycles later, and input
  // ready must stay low while the read is outstanding.
  initial begin
    int idx;
    stat_vld = 0;
    stat_mean = '0;
    stat_recip = '0;
    forever begin
      @(negedge clk);
      if (stat_rd_en) begin
        chk("rd_addr", 64'(stat_rd_addr), 64'(fetch_idx));
        chk("rd_expected", 64'(fetch_idx < exp_pix), 64'(1));
        chk("rdy_in_fetch", 64'(dat_in_rdy), 64'(0));
        idx = fetch_idx & 63;
        fetch_idx++;
        for (int i = 1; i <= stat_dly; i++) begin
          @(negedge clk);
          if (i == stat_dly) begin
            stat_vld = 1;
            stat_mean = mean_mem[idx];
            stat_recip = recip_mem[idx];
          end
          chk("rdy_in_wait", 64'(dat_in_rdy), 64'(0));
        end
        @(negedge clk);
        stat_vld = 0;
        stat_mean = DW'($urandom);
        stat_recip = (2*DW)'($urandom);
      end
    end
  end

  // Output monitor: pops the scoreboard and flags stray done pulses.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (dat_out_vld) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL out_unexpected actual=%0h expected=none (cyc %0d)", dat_out, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", 64'(dat_out), 64'(e.d));
          chk("out_last", 64'(dat_out_last), 64'(e.last));
          chk("out_latency", 64'(cyc), 64'(e.cyc));
        end
      end
      if (done && !awaiting_done) begin
        checks++;
        failures++;
        $display("FAIL done_unexpected actual=1 expected=0 (cyc %0d)", cyc);
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_rd_en"}, 64'(stat_rd_en), 64'(0));
    chk({tag, "_rd_addr"}, 64'(stat_rd_addr), 64'(0));
    chk({tag, "_rdy"}, 64'(dat_in_rdy), 64'(0));
    chk({tag, "_out_vld"}, 64'(dat_out_vld), 64'(0));
    chk({tag, "_out"}, 64'(dat_out), 64'(0));
    chk({tag, "_out_last"}, 64'(dat_out_last), 64'(0));
  endtask

  task automatic rand_stats(input int pix);
    for (int p = 0; p < pix; p++) begin
      mean_mem[p] = DW'($urandom);
      recip_mem[p] = (2*DW)'($urandom);
    end
  endtask

  // Run one layer. gap is the percent chance of an idle gap after each
  // beat. restart re-pulses start while busy. rst_mid resets during RUN.
  task automatic send_layer(input int pix, input int ch, input int sh, input int gap,
                            input bit restart, input bit rst_mid);
    int s;
    int last_c;
    int exp_done;
    int n;
    int beat_no;
    logic [BW-1:0] x;
    logic [BW-1:0] ed;
    logic signed [DW-1:0] xs;
    exp_t e;
    awaiting_done = 0;
    exp_pix = pix;
    fetch_idx = 0;
    @(negedge clk);
    cfg_pix_num = (AW+1)'(pix);
    cfg_ch_num = CW'(ch);
    cfg_shift = 5'(sh);
    start = 1;
    s = cyc;
    @(negedge clk);
    chk("busy_after_start", 64'(busy), 64'(1));
    if (restart) begin
      cfg_pix_num = (AW+1)'($urandom_range(1, 5));
      cfg_ch_num = CW'($urandom_range(1, 3));
      cfg_shift = 5'($urandom);
    end else begin
      start = 0;
    end
    @(negedge clk);
    start = 0;
    last_c = s;
    beat_no = 0;
    for (int p = 0; p < pix; p++) begin
      for (int c = 0; c < ch; c++) begin
        if (dir_q.size() > 0) x = dir_q.pop_front();
        else x = BW'($urandom);
        dat_in = x;
        dat_in_vld = 1;
        n = 0;
        while (!dat_in_rdy) begin
          @(negedge clk);
          n++;
          if (n > 200) begin
            checks++;
            failures++;
            $display("FAIL rdy_timeout actual=0 expected=1 (cyc %0d)", cyc);
            abort = 1;
            return;
          end
        end
        if (rst_mid && beat_no == 2) begin
          rst_n = 0;
          dat_in_vld = 0;
          #1;
          check_outputs_zero("rst_mid");
          exp_q.delete();
          repeat (2) @(negedge clk);
          rst_n = 1;
          repeat (8) @(negedge clk);
          return;
        end
        for (int l = 0; l < L; l++) begin
          xs = x[l*DW +: DW];
          ed[l*DW +: DW] = ref_norm(int'(xs), int'(mean_mem[p]), int'(recip_mem[p]), sh);
        end
        e.d = ed;
        e.last = (p == pix-1) && (c == ch-1);
        e.cyc = cyc + 3;
        exp_q.push_back(e);
        last_c = cyc;
        beat_no++;
        @(negedge clk);
        if (gap > 0 && $urandom_range(0, 99) < gap) begin
          dat_in_vld = 0;
          dat_in = BW'($urandom);
          repeat ($urandom_range(1, 3)) @(negedge clk);
        end
      end
    end
    dat_in_vld = 0;
    exp_done = last_c + 4;
    awaiting_done = 1;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=0 expected=1 (cyc %0d)", cyc);
    end else begin
      chk("done_cycle", 64'(cyc), 64'(exp_done));
      chk("busy_at_done", 64'(busy), 64'(0));
      chk("queue_empty_at_done", 64'(exp_q.size()), 64'(0));
    end
  endtask

  task automatic scen1();
    logic signed [DW-1:0] a, b, c, d;
    mean_mem[0] = 8'sd10;
    recip_mem[0] = 16'h0100;
    a = 8'sd20; b = 8'sd10; c = 8'sd0; d = -8'sd118;
    dir_q.push_back({d, c, b, a});
    send_layer(1, 1, 8, 0, 0, 0);
  endtask

  initial begin
    logic signed [DW-1:0] a, b, c, d;
    rst_n = 0;
    start = 0;
    cfg_pix_num = '0;
    cfg_ch_num = '0;
    cfg_shift = '0;
    dat_in_vld = 0;
    dat_in = '0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1;
    @(negedge clk);
    // Stray stat_vld in IDLE must be ignored.
    stat_vld = 1;
    stat_mean = 8'h55;
    stat_recip = 16'h1234;
    @(negedge clk);
    stat_vld = 0;

    // Directed: basic, saturation, rounding.
    scen1();
    mean_mem[0] = -8'sd128;
    recip_mem[0] = 16'hFFFF;
    a = 8'sd127; b = -8'sd128; c = -8'sd127; d = 8'sd0;
    dir_q.push_back({d, c, b, a});
    send_layer(1, 1, 8, 0, 0, 0);
    mean_mem[0] = 8'sd0;
    recip_mem[0] = 16'h0080;
    a = 8'sd1; b = -8'sd1; c = 8'sd3; d = -8'sd3;
    dir_q.push_back({d, c, b, a});
    send_layer(1, 1, 8, 0, 0, 0);

    // Multi-pixel, back-to-back input.
    rand_stats(3);
    send_layer(3, 2, 7, 0, 0, 0);

    // Slow stats, input gaps, and a start while busy.
    stat_dly = 5;
    rand_stats(2);
    send_layer(2, 3, 9, 40, 1, 0);
    stat_dly = 1;

    // Empty layer.
    send_layer(0, 1, 3, 0, 1, 0);

    // Reset mid-RUN, then a clean rerun.
    rand_stats(1);
    send_layer(1, 4, 8, 0, 0, 1);
    scen1();

    // Full address range.
    rand_stats(64);
    send_layer(64, 1, 10, 0, 0, 0);

    // Random layers.
    for (int k = 0; k < 12 && !abort; k++) begin
      int pix;
      pix = $urandom_range(1, 6);
      rand_stats(pix);
      stat_dly = $urandom_range(1, 3);
      send_layer(pix, $urandom_range(1, 4), $urandom_range(0, 31), 30, k[0], 0);
    end

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog actual=running expected=finished (cyc %0d)", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
